gray_ptr_cnt: RTL

Parametrised Gray-coded pointer counter for the asynchronous FIFO. Each FIFO clock domain holds one instance. The instance keeps the local read or write pointer in binary and Gray form, both registered. It also converts the peer domain's Gray pointer back to binary and produces a registered pointer difference, which the FIFO's full/empty logic consumes. It replaces the fixed 4-bit combinational binary-to-Gray conversion with a registered pointer of any width, glitch-free Gray output and a remote decode path.

---
 rtl/gray_ptr_cnt.sv | 92 +++++++++
 1 files changed

// File: rtl/gray_ptr_cnt.sv
// Gray-coded FIFO pointer counter: registered binary/Gray local pointer, peer Gray decode and pointer difference.
// Define GRAY_PTR_SYNC_EN to insert a two-flop synchroniser on rmt_gray ahead of the decode.
module gray_ptr_cnt #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              stop,
    input  logic [ADDR_W:0]   rmt_gray,
    output logic [ADDR_W:0]   ptr_bin,
    output logic [ADDR_W:0]   ptr_gray,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   rmt_bin,
    output logic [ADDR_W:0]   diff,
    output logic              wrap
);

    localparam int PW = ADDR_W + 1;

    generate
        if (ADDR_W < 2 || ADDR_W > 16) begin : g_bad_width
            $error("gray_ptr_cnt: ADDR_W must be within 2..16");
        end
    endgenerate

    logic          advance;
    logic [PW-1:0] bin_nxt;
    logic [PW-1:0] gray_nxt;
    logic [PW-1:0] rmt_g;
    logic [PW-1:0] rmt_dec;

    // Prefix-XOR from the MSB turns a Gray code back into binary.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        advance  = inc & ~stop;
        bin_nxt  = ptr_bin + PW'(1);
        gray_nxt = bin_nxt ^ (bin_nxt >> 1);
        rmt_dec  = gray2bin(rmt_g);
    end

`ifdef GRAY_PTR_SYNC_EN
    logic [PW-1:0] sync_q1;
    logic [PW-1:0] sync_q2;

    // Two-flop synchroniser; the peer pointer is Gray so at most one bit is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= rmt_gray;
            sync_q2 <= sync_q1;
        end
    end

    assign rmt_g = sync_q2;
`else
    assign rmt_g = rmt_gray;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            rmt_bin  <= '0;
            diff     <= '0;
            wrap     <= 1'b0;
        end else begin
            if (advance) begin
                ptr_bin  <= bin_nxt;
                ptr_gray <= gray_nxt;
            end
            wrap    <= advance && (addr == '1);
            rmt_bin <= rmt_dec;
            diff    <= ptr_bin - rmt_bin;
        end
    end

    assign addr = ptr_bin[ADDR_W-1:0];

endmodule
